mem_burst_writer: RTL
=====================

// Module: mem_burst_writer
// PURPOSE
//   Sequential memory writer. It is the write-side counterpart of the counter-driven ROM read path.
//   It accepts a data stream over a valid/ready handshake and issues one registered write strobe per accepted word.
//   Each strobe carries an auto-incrementing address and the captured data word.
//   It fills a RAM (or preloads table contents) that the read path later sweeps with its address counter.
// PARAMETERS
//   ADDR_W     8    width of address bus and address counter
//   DATA_W     8    width of data words
//   BURST_LEN  128  words written per start; legal range 1..2**ADDR_W
// PORTS
//   clk          in   1       system clock, rising edge
//   Reset        in   1       asynchronous reset, active-low
//   start        in   1       begin burst; sampled only in IDLE
//   abort        in   1       terminate burst; no done pulse
//   base_addr    in   ADDR_W  first write address, latched on start
//   in_data      in   DATA_W  stream data
//   in_valid     in   1       stream data valid
//   in_ready     out  1       writer can accept a word this cycle
//   WR           out  1       write strobe, one cycle per word
//   address      out  ADDR_W  write address, valid when WR=1
//   data         out  DATA_W  write data, valid when WR=1
//   busy         out  1       burst in progress (state != IDLE)
//   done         out  1       one-cycle pulse, burst complete
//   OV           out  1       one-cycle pulse, address wrapped max->0
// BEHAVIOUR
//   Reset
//     - Reset low forces state=IDLE immediately, independent of clk.
//     - All outputs go to 0; internal address and word counters go to 0.
//     - A partial burst is discarded; no done pulse is issued.
//   FSM IDLE -> WRITE -> DONE -> IDLE
//     - IDLE: in_ready=0, busy=0.
//       start=1 latches base_addr into the address counter, clears the word counter, and moves to WRITE.
//     - WRITE: in_ready=1.
//       A word is accepted when in_valid=1 and in_ready=1 at a rising edge.
//       Acceptance of word BURST_LEN-1 (0-based) moves the FSM to DONE.
//       abort=1 moves to IDLE; abort has priority over a same-cycle acceptance, so that word is dropped.
//     - DONE: in_ready=0, busy=1, done=1 for exactly this cycle; then returns to IDLE.
//   Write port
//     - Registered, latency 1. A word accepted at edge N drives WR=1 with its address and data during the cycle after edge N.
//     - The last word's WR cycle coincides with done=1.
//     - WR=0 when no word was accepted. address and data hold their last written values when WR=0.
//   Address arithmetic
//     - The address counter increments by 1 per accepted word, modulo 2**ADDR_W.
//     - OV=1 in the same cycle as the WR whose address is 2**ADDR_W-1.
//     - The burst then continues at address 0 and is not stopped.
//   Boundary cases
//     - start while busy is ignored.
//     - abort in IDLE or DONE is ignored.
//     - start and abort in the same IDLE cycle: start wins.
//     - Back-to-back bursts: start sampled in the cycle after DONE begins a new burst.
//     - in_valid is ignored while in_ready=0.
// TESTING
//   1. Reset low mid-activity -> all outputs 0 with no clk edge required.
//      Release, 3 idle cycles -> WR=0, busy=0.
//   2. base_addr=0x00, start, in_valid=1 continuously, in_data=k for word k
//      -> 128 consecutive WR pulses, address 0x00..0x7F, data 0x00..0x7F.
//      done=1 on the WR at 0x7F; in_ready=0 afterwards.
//   3. in_valid pattern 1,0,0,1,1,0,... -> WR only for accepted words; addresses contiguous with no gaps.
//      Total words 128; done occurs once.
//   4. base_addr=0xF0 -> addresses 0xF0..0xFF then 0x00..0x6F.
//      OV=1 only on the WR at 0xFF; done on the WR at 0x6F.
//   5. abort after word 10 (0x0A) accepted, in the same cycle as word 11 -> 11 WR pulses (0x00..0x0A), word 11 dropped.
//      No done; busy=0 next cycle. A new start works normally.
//   6. start pulsed while busy and in the DONE cycle -> ignored while busy.
//      Start in the cycle after DONE -> second burst of 128 words.

Source files
------------

// File: rtl/mem_burst_writer.sv
// Streaming RAM writer: accepts words over valid/ready and emits one registered
// write strobe per word at an auto-incrementing address.
//
// state   | meaning
// S_IDLE  | waiting for start; in_ready=0, busy=0
// S_WRITE | accepting words; in_ready=1
// S_DONE  | one-cycle completion pulse; coincides with the last word's WR
module mem_burst_writer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 128
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              WR,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              OV
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic              accept;
  logic              load;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // abort outranks a same-cycle word, so accept is never raised alongside it
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        in_ready = 1'b1;
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (in_valid) begin
          accept = 1'b1;
          if (word_cnt == LAST_WORD) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      WR       <= 1'b0;
      OV       <= 1'b0;
      address  <= '0;
      data     <= '0;
      addr_cnt <= '0;
      word_cnt <= '0;
    end else begin
      WR <= accept;
      OV <= accept && (addr_cnt == ADDR_MAX);
      if (load) begin
        addr_cnt <= base_addr;
        word_cnt <= '0;
      end else if (accept) begin
        address  <= addr_cnt;
        data     <= in_data;
        addr_cnt <= addr_cnt + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule
